// File: rtl/sum_nb_seq.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB slice first,
// with a carry register between slices; reports carry/borrow and signed overflow.
module sum_nb_seq #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic             sub,
   input  logic [WIDTH-1:0] xi,
   input  logic [WIDTH-1:0] yi,
   output logic [WIDTH-1:0] zi,
   output logic             co,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int unsigned NCH = WIDTH / CHUNK;
   localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [KW-1:0] KLAST = KW'(NCH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry;
   logic [KW-1:0]    k;
   logic [CHUNK:0]   slice_sum;
   logic             msb_cin;

   // Operands shift right one slice per RUN cycle, so the active slice is
   // always the low CHUNK bits; on the last slice that holds the operand MSBs.
   always_comb begin
      slice_sum = {1'b0, a[CHUNK-1:0]} + {1'b0, b[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
      msb_cin   = a[CHUNK-1] ^ b[CHUNK-1] ^ slice_sum[CHUNK-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         a     <= '0;
         b     <= '0;
         carry <= 1'b0;
         k     <= '0;
         zi    <= '0;
         co    <= 1'b0;
         ovf   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (init) begin
                  a     <= xi;
                  b     <= sub ? ~yi : yi;
                  carry <= sub;
                  k     <= '0;
                  zi    <= '0;
                  co    <= 1'b0;
                  ovf   <= 1'b0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               zi[k*CHUNK +: CHUNK] <= slice_sum[CHUNK-1:0];
               a     <= a >> CHUNK;
               b     <= b >> CHUNK;
               carry <= slice_sum[CHUNK];
               k     <= k + 1'b1;
               if (k == KLAST) begin
                  co    <= slice_sum[CHUNK];
                  ovf   <= msb_cin ^ slice_sum[CHUNK];
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sum_nb_seq.sv
// Bench for sum_nb_seq: three configurations (16/4, 16/16, 8/2) checked every
// cycle against an arithmetic reference model, plus literal directed cases.
module tb_sum_nb_seq;

   localparam int NCFG = 3;
   localparam int NOPS = 1000;
   localparam int NLIT = 8;

   function automatic int cfg_w(input int g);
      return (g == 2) ? 8 : 16;
   endfunction

   function automatic int cfg_c(input int g);
      case (g)
         0:       return 4;
         1:       return 16;
         default: return 2;
      endcase
   endfunction

   typedef struct {
      logic [15:0] z;
      logic        c;
      logic        v;
   } res_t;

   // Reference result from plain integer arithmetic on WIDTH-bit values.
   function automatic res_t ref_op(input int w, input logic [15:0] x, input logic [15:0] y,
                                   input logic s);
      res_t   r;
      longint full, ux, uy, sx, sy, sr, raw;
      full = longint'(1) << w;
      ux   = longint'(x) & (full - 1);
      uy   = longint'(y) & (full - 1);
      raw  = s ? ux - uy : ux + uy;
      r.z  = 16'(raw & (full - 1));
      r.c  = s ? (ux >= uy) : (ux + uy >= full);
      sx   = (ux >= full / 2) ? ux - full : ux;
      sy   = (uy >= full / 2) ? uy - full : uy;
      sr   = s ? sx - sy : sx + sy;
      r.v  = (sr < -(full / 2)) || (sr >= full / 2);
      return r;
   endfunction

   logic        clk = 1'b0;
   logic        rst;
   logic        init_v [NCFG];
   logic        sub_v  [NCFG];
   logic [15:0] xi_v   [NCFG];
   logic [15:0] yi_v   [NCFG];
   logic [15:0] zi_v   [NCFG];
   logic        co_v   [NCFG];
   logic        ovf_v  [NCFG];
   logic        busy_v [NCFG];
   logic        done_v [NCFG];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NCFG; g++) begin : gen_cfg
      localparam int unsigned W = cfg_w(g);
      localparam int unsigned C = cfg_c(g);
      logic [W-1:0] zi_l;
      sum_nb_seq #(.WIDTH(W), .CHUNK(C)) dut (
         .clk  (clk),
         .rst  (rst),
         .init (init_v[g]),
         .sub  (sub_v[g]),
         .xi   (xi_v[g][W-1:0]),
         .yi   (yi_v[g][W-1:0]),
         .zi   (zi_l),
         .co   (co_v[g]),
         .ovf  (ovf_v[g]),
         .busy (busy_v[g]),
         .done (done_v[g])
      );
      assign zi_v[g] = 16'(zi_l);
   end

   // Model: mcyc = -1 when idle, otherwise cycles elapsed since the accepting edge.
   int          mcyc [NCFG];
   res_t        mres [NCFG];
   logic [15:0] mzi  [NCFG];
   logic        mco  [NCFG];
   logic        movf [NCFG];
   int          ops  [NCFG] = '{0, 0, 0};
   int          cyc_no = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int g = 0; g < NCFG; g++) begin
            mcyc[g] <= -1;
            mzi[g]  <= '0;
            mco[g]  <= 1'b0;
            movf[g] <= 1'b0;
         end
      end else begin
         cyc_no <= cyc_no + 1;
         for (int g = 0; g < NCFG; g++) begin
            automatic int n = cfg_w(g) / cfg_c(g);
            automatic int c = mcyc[g];
            if (c < 0) begin
               if (init_v[g] === 1'b1) begin
                  mres[g] <= ref_op(cfg_w(g), xi_v[g], yi_v[g], sub_v[g]);
                  mcyc[g] <= 0;
                  mzi[g]  <= '0;
                  mco[g]  <= 1'b0;
                  movf[g] <= 1'b0;
               end
            end else if (c == n) begin
               mcyc[g] <= -1;
            end else begin
               mcyc[g] <= c + 1;
               if (c + 1 == n) begin
                  mzi[g]  <= mres[g].z;
                  mco[g]  <= mres[g].c;
                  movf[g] <= mres[g].v;
                  ops[g]  <= ops[g] + 1;
               end else begin
                  mzi[g] <= 16'(longint'(mres[g].z) & ((longint'(1) << ((c + 1) * cfg_c(g))) - 1));
               end
            end
         end
      end
   end

   int          checks = 0;
   int          failures = 0;
   int          lit_id = 0;
   int          lit_seen = 0;
   int          lit_acc = 0;
   logic [15:0] lit_z = '0;
   logic        lit_co = 1'b0;
   logic        lit_ovf = 1'b0;
   logic        end_req = 1'b0;
   logic        end_done = 1'b0;

   always begin
      @(negedge clk or posedge rst);
      if (rst) #1;
      for (int g = 0; g < NCFG; g++) begin
         automatic int   n  = cfg_w(g) / cfg_c(g);
         automatic logic eb = (mcyc[g] >= 0) && (mcyc[g] < n);
         automatic logic ed = (mcyc[g] == n);
         checks++;
         if ({zi_v[g], co_v[g], ovf_v[g], busy_v[g], done_v[g]} !== {mzi[g], mco[g], movf[g], eb, ed}) begin
            failures++;
            $display("FAIL cfg%0d_outputs t=%0t: got zi=%h co=%b ovf=%b busy=%b done=%b, expected zi=%h co=%b ovf=%b busy=%b done=%b",
                     g, $time, zi_v[g], co_v[g], ovf_v[g], busy_v[g], done_v[g],
                     mzi[g], mco[g], movf[g], eb, ed);
         end
      end
      if (!rst && done_v[0] === 1'b1 && lit_id != lit_seen) begin
         lit_seen = lit_id;
         checks++;
         if (zi_v[0] !== lit_z || co_v[0] !== lit_co || ovf_v[0] !== lit_ovf || cyc_no - lit_acc != 4) begin
            failures++;
            $display("FAIL literal_%0d: got zi=%h co=%b ovf=%b latency=%0d, expected zi=%h co=%b ovf=%b latency=4",
                     lit_id, zi_v[0], co_v[0], ovf_v[0], cyc_no - lit_acc, lit_z, lit_co, lit_ovf);
         end
      end
      if (end_req && !end_done) begin
         end_done = 1'b1;
         for (int g = 0; g < NCFG; g++) begin
            checks++;
            if (ops[g] < NOPS) begin
               failures++;
               $display("FAIL cfg%0d_op_count: got %0d completed ops, expected at least %0d", g, ops[g], NOPS);
            end
         end
         checks++;
         if (lit_seen != NLIT) begin
            failures++;
            $display("FAIL literal_count: got %0d literal results seen, expected %0d", lit_seen, NLIT);
         end
      end
   end

   task automatic arm_start(input logic [15:0] x, input logic [15:0] y, input logic s,
                            input logic [15:0] ez, input logic eco, input logic eovf);
      @(negedge clk);
      xi_v[0]   = x;
      yi_v[0]   = y;
      sub_v[0]  = s;
      init_v[0] = 1'b1;
      @(negedge clk);
      init_v[0] = 1'b0;
      lit_acc   = cyc_no;
      lit_z     = ez;
      lit_co    = eco;
      lit_ovf   = eovf;
      lit_id++;
   endtask

   task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                         input logic [15:0] ez, input logic eco, input logic eovf);
      arm_start(x, y, s, ez, eco, eovf);
      repeat (6) @(negedge clk);
   endtask

   function automatic logic [15:0] pick();
      case ($urandom_range(9))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h8000;
         3:       return 16'h7FFF;
         4:       return 16'h0080;
         5:       return 16'h007F;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      for (int g = 0; g < NCFG; g++) begin
         init_v[g] = 1'b0;
         sub_v[g]  = 1'b0;
         xi_v[g]   = '0;
         yi_v[g]   = '0;
      end
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_op(16'h0007, 16'h0007, 1'b1, 16'h0000, 1'b1, 1'b0);

      // Second init and operand changes while running must be ignored.
      arm_start(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
      init_v[0] = 1'b1;
      xi_v[0]   = 16'hAAAA;
      yi_v[0]   = 16'h5555;
      sub_v[0]  = 1'b1;
      repeat (2) @(negedge clk);
      init_v[0] = 1'b0;
      repeat (6) @(negedge clk);

      // Abort mid-operation with an asynchronous reset after slice 2 is written.
      @(negedge clk);
      xi_v[0]   = 16'h1234;
      yi_v[0]   = 16'h1111;
      sub_v[0]  = 1'b0;
      init_v[0] = 1'b1;
      @(negedge clk);
      init_v[0] = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_op(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);

      for (int guard = 0; guard < 40000; guard++) begin
         if (ops[0] >= NOPS && ops[1] >= NOPS && ops[2] >= NOPS) break;
         @(negedge clk);
         for (int g = 0; g < NCFG; g++) begin
            init_v[g] = ($urandom_range(3) != 0);
            sub_v[g]  = 1'($urandom_range(1));
            xi_v[g]   = pick();
            yi_v[g]   = pick();
         end
      end
      for (int g = 0; g < NCFG; g++) init_v[g] = 1'b0;

      end_req = 1'b1;
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
